// File: rtl/axi_ts_trig_cond.sv
// -----------------------------------------------------------------------------
// axi_ts_trig_cond
// Conditions an asynchronous board-level trigger pin for the trigger subsystem:
// synchroniser -> glitch filter -> edge select -> holdoff FSM -> one-cycle
// qualified pulse, stamped with RTC seconds/nanoseconds and counted.
//
// Ports
//   aclk, aresetn       clock, asynchronous active-low reset
//   trig_in             raw asynchronous trigger pin
//   cfg_enable          1 = triggers may be emitted
//   cfg_edge            00 rising, 01 falling, 10 both, 11 none
//   cfg_filter_len      cycles a new level must persist beyond the first
//   cfg_holdoff         dead cycles after each emitted trigger
//   cnt_clear           single-cycle pulse, clears counters
//   rtc_sec, rtc_nsec   RTC time
//   trig_out            qualified one-cycle trigger pulse
//   trig_sec/trig_nsec  RTC time captured at the last trigger
//   trig_count          emitted-trigger count (wraps)
//   missed_count        edges suppressed by holdoff (saturating)
//
// Build option: define TS_TRIG_MISSED_CNT_EN to build the missed_count
// counter; otherwise missed_count is tied to 0.
// -----------------------------------------------------------------------------
module axi_ts_trig_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int HOLD_W      = 24
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              trig_in,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_edge,
    input  logic [FILT_W-1:0] cfg_filter_len,
    input  logic [HOLD_W-1:0] cfg_holdoff,
    input  logic              cnt_clear,
    input  logic [31:0]       rtc_sec,
    input  logic [31:0]       rtc_nsec,
    output logic              trig_out,
    output logic [31:0]       trig_sec,
    output logic [31:0]       trig_nsec,
    output logic [31:0]       trig_count,
    output logic [15:0]       missed_count
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_HOLDOFF = 1'b1;

    // The arm counter runs to SYNC_STAGES+1 (at most 5), so 3 bits suffice.
    localparam int             ARM_W    = 3;
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    // ---------------- synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   sync_out;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = trig_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // ---------------- arming / filter / edge ----------------
    logic [ARM_W-1:0]  arm_reg;
    logic              armed;
    logic              filt_reg, filt_next;
    logic              filt_d_reg, filt_d_next;
    logic [FILT_W-1:0] fcnt_reg, fcnt_next;
    logic              edge_hit;
    logic              qualified_edge;

    assign armed = (arm_reg == ARM_DONE);

    always_comb begin
        filt_next   = filt_reg;
        filt_d_next = filt_reg;
        fcnt_next   = '0;
        if (!armed) begin
            // While arming, both the level and its delayed copy follow the
            // synchroniser so that a pin already high at release is not
            // mistaken for an edge once arming completes.
            filt_next   = sync_out;
            filt_d_next = sync_out;
        end else if (sync_out != filt_reg) begin
            if (fcnt_reg >= cfg_filter_len) begin
                filt_next = sync_out;
            end else begin
                fcnt_next = fcnt_reg + FILT_W'(1);
            end
        end
    end

    always_comb begin
        edge_hit = 1'b0;
        case (cfg_edge)
            2'b00:   edge_hit =  filt_reg & ~filt_d_reg;
            2'b01:   edge_hit = ~filt_reg &  filt_d_reg;
            2'b10:   edge_hit =  filt_reg ^  filt_d_reg;
            default: edge_hit = 1'b0;
        endcase
    end

    assign qualified_edge = armed & edge_hit;

    // ---------------- holdoff FSM ----------------
    logic [0:0]        state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              trig_out_reg, trig_out_next;
    logic              fire;
    logic [31:0]       trig_sec_reg, trig_nsec_reg;
    logic [31:0]       trig_count_reg, trig_count_next;

    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        trig_out_next = 1'b0;
        fire          = 1'b0;
        if (!cfg_enable) begin
            state_next = ST_IDLE;
            hold_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (qualified_edge) begin
                        trig_out_next = 1'b1;
                        fire          = 1'b1;
                        if (cfg_holdoff != '0) begin
                            hold_next  = cfg_holdoff;
                            state_next = ST_HOLDOFF;
                        end
                    end
                end
                default: begin
                    // Count 1 is the last dead cycle; the next one is live.
                    if (hold_reg <= HOLD_W'(1)) begin
                        hold_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        hold_next = hold_reg - HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    // A trigger coincident with a clear still counts itself.
    always_comb begin
        trig_count_next = trig_count_reg;
        if (fire) begin
            trig_count_next = cnt_clear ? 32'd1 : trig_count_reg + 32'd1;
        end else if (cnt_clear) begin
            trig_count_next = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_reg       <= '0;
            arm_reg        <= '0;
            filt_reg       <= 1'b0;
            filt_d_reg     <= 1'b0;
            fcnt_reg       <= '0;
            state_reg      <= ST_IDLE;
            hold_reg       <= '0;
            trig_out_reg   <= 1'b0;
            trig_sec_reg   <= '0;
            trig_nsec_reg  <= '0;
            trig_count_reg <= '0;
        end else begin
            sync_reg       <= sync_next;
            if (!armed) begin
                arm_reg <= arm_reg + ARM_W'(1);
            end
            filt_reg       <= filt_next;
            filt_d_reg     <= filt_d_next;
            fcnt_reg       <= fcnt_next;
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            trig_out_reg   <= trig_out_next;
            trig_count_reg <= trig_count_next;
            if (fire) begin
                trig_sec_reg  <= rtc_sec;
                trig_nsec_reg <= rtc_nsec;
            end
        end
    end

    assign trig_out   = trig_out_reg;
    assign trig_sec   = trig_sec_reg;
    assign trig_nsec  = trig_nsec_reg;
    assign trig_count = trig_count_reg;

`ifdef TS_TRIG_MISSED_CNT_EN
    logic [15:0] missed_reg;
    logic        missed_hit;

    assign missed_hit = cfg_enable & (state_reg == ST_HOLDOFF) & qualified_edge;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            missed_reg <= '0;
        end else if (cnt_clear) begin
            missed_reg <= '0;
        end else if (missed_hit && (missed_reg != 16'hFFFF)) begin
            missed_reg <= missed_reg + 16'd1;
        end
    end

    assign missed_count = missed_reg;
`else
    assign missed_count = '0;
`endif

endmodule

// File: tb/tb_axi_ts_trig_cond.sv
module tb_axi_ts_trig_cond;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 8;
    localparam int HOLD_W      = 24;
`ifdef TS_TRIG_MISSED_CNT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              trig_in = 1'b0;
    logic              cfg_enable = 1'b0;
    logic [1:0]        cfg_edge = 2'b00;
    logic [FILT_W-1:0] cfg_filter_len = '0;
    logic [HOLD_W-1:0] cfg_holdoff = '0;
    logic              cnt_clear = 1'b0;
    logic [31:0]       rtc_sec = 32'd5;
    logic [31:0]       rtc_nsec = 32'd100;
    logic              trig_out;
    logic [31:0]       trig_sec, trig_nsec, trig_count;
    logic [15:0]       missed_count;

    axi_ts_trig_cond #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W), .HOLD_W(HOLD_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .trig_in(trig_in),
        .cfg_enable(cfg_enable), .cfg_edge(cfg_edge),
        .cfg_filter_len(cfg_filter_len), .cfg_holdoff(cfg_holdoff),
        .cnt_clear(cnt_clear), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
        .trig_out(trig_out), .trig_sec(trig_sec), .trig_nsec(trig_nsec),
        .trig_count(trig_count), .missed_count(missed_count)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // RTC: seconds fixed; nanoseconds either fixed at 100 or tracking cyc.
    bit rtc_run = 1'b0;
    always @(negedge aclk) rtc_nsec <= rtc_run ? 32'(cyc) : 32'd100;

    typedef struct {
        int          cyc;
        logic [31:0] sec;
        logic [31:0] nsec;
        logic [31:0] count;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_count = '0;
    int          exp_missed = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, req, cyc);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Expected trigger observed at the negedge where cyc == at.
    task automatic expect_trig(input int at);
        exp_t e;
        exp_count = exp_count + 32'd1;
        e.cyc   = at;
        e.sec   = 32'd5;
        e.nsec  = rtc_run ? 32'(at - 1) : 32'd100;
        e.count = exp_count;
        sb_q.push_back(e);
    endtask

    // Reconfigure with triggers disabled so level changes cannot fire.
    task automatic settle(input logic [1:0] e, input int l, input logic lvl);
        cfg_enable     = 1'b0;
        cfg_edge       = e;
        cfg_filter_len = FILT_W'(l);
        trig_in        = lvl;
        tick(12);
        cfg_enable = 1'b1;
        tick(2);
    endtask

    // Scoreboard monitor: every trig_out pulse must match the queue head.
    always @(negedge aclk) begin
        if (trig_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_trig actual=pulse required=none cyc=%0d count=%0d", cyc, trig_count);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("trig_cycle", 64'(cyc), 64'(e.cyc));
                check("trig_sec", 64'(trig_sec), 64'(e.sec));
                check("trig_nsec", 64'(trig_nsec), 64'(e.nsec));
                check("trig_count", 64'(trig_count), 64'(e.count));
            end
        end
        if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_trig actual=none required=pulse at cyc=%0d now=%0d", sb_q[0].cyc, cyc);
            void'(sb_q.pop_front());
        end
    end

    typedef struct {
        logic [1:0] edge_sel;
        int         flen;
        logic       init;
        int         plen;      // 0 = single step
        bit         exp_first;
        bit         exp_second;
    } vec_t;

    vec_t vecs[9];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trig_out"}, 64'(trig_out), 64'd0);
        check({tag, "_sec"}, 64'(trig_sec), 64'd0);
        check({tag, "_nsec"}, 64'(trig_nsec), 64'd0);
        check({tag, "_count"}, 64'(trig_count), 64'd0);
        check({tag, "_missed"}, 64'(missed_count), 64'd0);
    endtask

    initial begin
        int c;
        vecs[0] = '{2'b00, 0, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{2'b00, 3, 1'b0, 3, 1'b0, 1'b0};
        vecs[2] = '{2'b00, 3, 1'b0, 4, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 0, 1'b0, 0, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 0, 1'b1, 0, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 2, 1'b0, 5, 1'b1, 1'b1};
        vecs[6] = '{2'b11, 0, 1'b0, 4, 1'b0, 1'b0};
        vecs[7] = '{2'b10, 1, 1'b1, 1, 1'b0, 1'b0};
        vecs[8] = '{2'b00, 1, 1'b0, 2, 1'b1, 1'b0};

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        tick(6);

        // Table-driven single-edge / pulse vectors
        for (int i = 0; i < 9; i++) begin
            settle(vecs[i].edge_sel, vecs[i].flen, vecs[i].init);
            c = cyc;
            trig_in = ~vecs[i].init;
            if (vecs[i].exp_first) expect_trig(c + 4 + vecs[i].flen);
            if (vecs[i].plen > 0) begin
                tick(vecs[i].plen);
                trig_in = vecs[i].init;
                if (vecs[i].exp_second) expect_trig(c + vecs[i].plen + 4 + vecs[i].flen);
            end
            tick(20);
            $display("vec %0d edge=%0b flen=%0d plen=%0d count=%0d", i, vecs[i].edge_sel,
                     vecs[i].flen, vecs[i].plen, trig_count);
            check("vec_count", 64'(trig_count), 64'(exp_count));
            check("vec_drain", 64'(sb_q.size()), 64'd0);
        end

        // Holdoff: edges at 0, 5, 20 with holdoff 10
        rtc_run = 1'b1;
        cfg_holdoff = HOLD_W'(10);
        settle(2'b10, 0, 1'b0);
        c = cyc;
        trig_in = 1'b1;
        expect_trig(c + 4);
        tick(5);
        trig_in = 1'b0;
        tick(15);
        trig_in = 1'b1;
        expect_trig(c + 24);
        tick(20);
        if (MISS_EN) exp_missed = exp_missed + 1;
        $display("holdoff10 count=%0d missed=%0d", trig_count, missed_count);
        check("hold10_count", 64'(trig_count), 64'(exp_count));
        check("hold10_missed", 64'(missed_count), 64'(exp_missed));

        // Holdoff boundary: edge at T+3 ignored, T+4 accepted
        cfg_holdoff = HOLD_W'(3);
        settle(2'b10, 0, 1'b0);
        c = cyc;
        trig_in = 1'b1;
        expect_trig(c + 4);
        tick(3);
        trig_in = 1'b0;
        tick(1);
        trig_in = 1'b1;
        expect_trig(c + 8);
        tick(20);
        if (MISS_EN) exp_missed = exp_missed + 1;
        $display("holdoff3 count=%0d missed=%0d", trig_count, missed_count);
        check("hold3_count", 64'(trig_count), 64'(exp_count));
        check("hold3_missed", 64'(missed_count), 64'(exp_missed));

        // Stand-alone clear
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        tick(1);
        exp_count = '0;
        exp_missed = 0;
        $display("clear count=%0d missed=%0d", trig_count, missed_count);
        check("clear_count", 64'(trig_count), 64'(exp_count));
        check("clear_missed", 64'(missed_count), 64'(exp_missed));

        // Pin high through reset release: no trigger, then a falling edge
        cfg_holdoff = '0;
        cfg_filter_len = '0;
        cfg_edge = 2'b10;
        cfg_enable = 1'b1;
        trig_in = 1'b1;
        aresetn = 1'b0;
        tick(2);
        exp_count = '0;
        exp_missed = 0;
        aresetn = 1'b1;
        tick(20);
        check("armhigh_count", 64'(trig_count), 64'd0);
        cfg_edge = 2'b01;
        tick(1);
        c = cyc;
        trig_in = 1'b0;
        expect_trig(c + 4);
        tick(20);
        $display("armhigh fall count=%0d", trig_count);
        check("armfall_count", 64'(trig_count), 64'(exp_count));

        // Wrap 0xFFFFFFFF -> 0
        cfg_edge = 2'b00;
        force dut.trig_count_reg = 32'hFFFF_FFFF;
        tick(1);
        release dut.trig_count_reg;
        tick(1);
        exp_count = 32'hFFFF_FFFF;
        c = cyc;
        trig_in = 1'b1;
        expect_trig(c + 4);
        tick(20);
        $display("wrap count=%0d", trig_count);
        check("wrap_count", 64'(trig_count), 64'd0);

        // Clear coincident with a trigger gives 1
        trig_in = 1'b0;
        tick(5);
        exp_count = '0;
        c = cyc;
        trig_in = 1'b1;
        expect_trig(c + 4);
        tick(3);
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        tick(20);
        $display("clear+trig count=%0d", trig_count);
        check("clrtrig_count", 64'(trig_count), 64'd1);

        // Asynchronous reset in the middle of a long holdoff
        cfg_holdoff = HOLD_W'(50);
        cfg_edge = 2'b10;
        tick(1);
        c = cyc;
        trig_in = 1'b0;
        expect_trig(c + 4);
        tick(10);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_count = '0;
        exp_missed = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        tick(10);
        c = cyc;
        trig_in = 1'b1;
        expect_trig(c + 4);
        tick(20);
        $display("post-reset count=%0d missed=%0d", trig_count, missed_count);
        check("postrst_count", 64'(trig_count), 64'(exp_count));
        check("postrst_drain", 64'(sb_q.size()), 64'd0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
